axil_reg_bank: RTL and testbench

// - AXI4-Lite slave register bank. It is the downstream consumer of the APB-to-AXI-Lite bridge's master port.
// - Holds NUM_REGS read/write control words and drives them to peripheral logic.
// - Pulses a per-register write strobe on every successful write.
// - Out-of-range accesses complete with SLVERR, so the bridge maps them to pslverr.

---
 rtl/axil_reg_bank_pkg.sv | 68 ++++++
 rtl/axil_reg_bank_if.sv | 12 +
 rtl/axil_reg_bank.sv | 186 ++++++++++++++++++
 tb/tb_axil_reg_bank.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_reg_bank_pkg.sv
// Shared types, response codes and helpers for the AXI4-Lite register bank.
package axil_reg_bank_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            prot;
  } axi_ax_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } axi_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    logic   ar_ready;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;

  typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_t;

  // Byte-lane merge: lanes with strb set take the new byte, others keep the old one.
  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite request/response bundle between an upstream master and the register bank.
// Handshake rule on every channel: a transfer happens on the posedge where valid and
// ready are both high; once valid is raised, the payload stays stable until that edge.
interface axil_reg_bank_if;
  import axil_reg_bank_pkg::*;

  axi_req_t  req;
  axi_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS control words with byte strobes,
// per-register write pulses and SLVERR on out-of-range accesses.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int                    NUM_REGS  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  axil_reg_bank_if.slave                      axi,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]                 wr_pulse_o,
  output wr_state_t                           wr_state_o,
  output rd_state_t                           rd_state_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] END_ADDR =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * NUM_REGS);

  // One extra address bit so a bank at the top of the map cannot wrap.
  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  wr_state_t                           wr_state;
  rd_state_t                           rd_state;
  logic                                aw_held, w_held;
  logic [ADDR_WIDTH-1:0]               aw_addr_q;
  logic [DATA_WIDTH-1:0]               w_data_q;
  logic [STRB_WIDTH-1:0]               w_strb_q;
  logic                                b_valid_q;
  logic [1:0]                          b_resp_q;
  logic                                r_valid_q;
  logic [DATA_WIDTH-1:0]               r_data_q;
  logic [1:0]                          r_resp_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q;
  logic [NUM_REGS-1:0]                 pulse_q;

  logic                  aw_ready, w_ready, ar_ready;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_hit, rd_hit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  axi_resp_t             resp_d;
  logic                  unused_prot;

  assign aw_ready = (wr_state == WR_IDLE) && !aw_held;
  assign w_ready  = (wr_state == WR_IDLE) && !w_held;
  assign ar_ready = (rd_state == RD_IDLE);

  assign aw_hs = axi.req.aw_valid && aw_ready;
  assign w_hs  = axi.req.w_valid  && w_ready;
  assign ar_hs = axi.req.ar_valid && ar_ready;

  // A held beat wins over the live bus, so AW and W may arrive in either order.
  assign wr_addr = aw_held ? aw_addr_q : axi.req.aw.addr;
  assign wr_data = w_held  ? w_data_q  : axi.req.w.data;
  assign wr_strb = w_held  ? w_strb_q  : axi.req.w.strb;
  assign commit  = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_hit = addr_hit(wr_addr);
  assign wr_idx = addr_idx(wr_addr);
  assign rd_hit = addr_hit(axi.req.ar.addr);
  assign rd_idx = addr_idx(axi.req.ar.addr);

  assign unused_prot = ^{axi.req.aw.prot, axi.req.ar.prot};

  // Write FSM: latch AW/W independently, commit once both are present, then hold B.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state  <= WR_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= AXI_RESP_OKAY;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= axi.req.aw.addr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= axi.req.w.data;
            w_strb_q <= axi.req.w.strb;
          end
          if (commit) begin
            wr_state  <= WR_RESP;
            b_valid_q <= 1'b1;
            b_resp_q  <= wr_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          end
        end
        WR_RESP: begin
          if (axi.req.b_ready) begin
            wr_state  <= WR_IDLE;
            b_valid_q <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Register array and write pulses update on the commit edge together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_q   <= {NUM_REGS{RESET_VAL}};
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (commit && wr_hit) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_idx == IDX_W'(i)) begin
            reg_q[i]   <= apply_strb(reg_q[i], wr_data, wr_strb);
            pulse_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read FSM: capture the pre-edge register value on AR, hold R until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state  <= RD_IDLE;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= AXI_RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state  <= RD_RESP;
            r_valid_q <= 1'b1;
            r_data_q  <= rd_hit ? reg_q[rd_idx] : '0;
            r_resp_q  <= rd_hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          end
        end
        RD_RESP: begin
          if (axi.req.r_ready) begin
            rd_state  <= RD_IDLE;
            r_valid_q <= 1'b0;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Pack the response bundle from the state above.
  always_comb begin
    resp_d          = '0;
    resp_d.aw_ready = aw_ready;
    resp_d.w_ready  = w_ready;
    resp_d.b.resp   = b_resp_q;
    resp_d.b_valid  = b_valid_q;
    resp_d.ar_ready = ar_ready;
    resp_d.r.data   = r_data_q;
    resp_d.r.resp   = r_resp_q;
    resp_d.r_valid  = r_valid_q;
  end

  assign axi.resp   = resp_d;
  assign reg_o      = reg_q;
  assign wr_pulse_o = pulse_q;
  assign wr_state_o = wr_state;
  assign rd_state_o = rd_state;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: a write/read vector table plus hand-written
// sequences for split AW/W, backpressure, same-edge access and mid-transaction reset.
module tb_axil_reg_bank;
  import axil_reg_bank_pkg::*;

  localparam int NR = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_reg_bank_if bus();

  logic [NR-1:0][31:0] regs;
  logic [NR-1:0]       pulse;
  wr_state_t           wr_st;
  rd_state_t           rd_st;

  axil_reg_bank #(
    .NUM_REGS  (NR),
    .BASE_ADDR (32'h0000_0000),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .axi        (bus),
    .reg_o      (regs),
    .wr_pulse_o (pulse),
    .wr_state_o (wr_st),
    .rd_state_o (rd_st)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_mem [NR];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        hit;
    int          idx;
    logic [31:0] exp_reg;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_all_regs(input string tag);
    for (int i = 0; i < NR; i++) chk($sformatf("%s reg%0d", tag, i), regs[i], exp_mem[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input logic [7:0] exp_pulse,
                          input string tag);
    chk({tag, " aw_ready"}, 32'(bus.resp.aw_ready), 32'd1);
    bus.req.aw.addr  = a;
    bus.req.aw_valid = 1'b1;
    bus.req.w.data   = d;
    bus.req.w.strb   = s;
    bus.req.w_valid  = 1'b1;
    bus.req.b_ready  = 1'b1;
    tick();
    bus.req.aw_valid = 1'b0;
    bus.req.w_valid  = 1'b0;
    chk({tag, " b_valid"}, 32'(bus.resp.b_valid), 32'd1);
    chk({tag, " b_resp"}, 32'(bus.resp.b.resp), 32'(exp_resp));
    chk({tag, " pulse"}, 32'(pulse), 32'(exp_pulse));
    chk_all_regs(tag);
    tick();
    chk({tag, " b_done"}, 32'(bus.resp.b_valid), 32'd0);
    chk({tag, " pulse_clr"}, 32'(pulse), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    chk({tag, " ar_ready"}, 32'(bus.resp.ar_ready), 32'd1);
    bus.req.ar.addr  = a;
    bus.req.ar_valid = 1'b1;
    bus.req.r_ready  = 1'b1;
    exp_q.push_back(exp_data);
    tick();
    bus.req.ar_valid = 1'b0;
    chk({tag, " r_valid"}, 32'(bus.resp.r_valid), 32'd1);
    chk({tag, " r_data"}, bus.resp.r.data, exp_q.pop_front());
    chk({tag, " r_resp"}, 32'(bus.resp.r.resp), 32'(exp_resp));
    tick();
    chk({tag, " r_done"}, 32'(bus.resp.r_valid), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] ep;

    tbl[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 4'hF,    1'b1, 1, 32'hDEAD_BEEF, 2'b00};
    tbl[1] = '{32'h0000_0008, 32'hFFFF_FFFF, 4'hF,    1'b1, 2, 32'hFFFF_FFFF, 2'b00};
    tbl[2] = '{32'h0000_000C, 32'h1234_5678, 4'b0011, 1'b1, 3, 32'h0000_5678, 2'b00};
    tbl[3] = '{32'h0000_000D, 32'hAABB_CCDD, 4'b1100, 1'b1, 3, 32'hAABB_5678, 2'b00};
    tbl[4] = '{32'h0000_001C, 32'hCAFE_F00D, 4'hF,    1'b1, 7, 32'hCAFE_F00D, 2'b00};
    tbl[5] = '{32'h0000_0010, 32'h5555_5555, 4'h0,    1'b1, 4, 32'h0000_0000, 2'b00};
    tbl[6] = '{32'h0000_0020, 32'h1111_1111, 4'hF,    1'b0, 0, 32'h0000_0000, 2'b10};
    tbl[7] = '{32'hFFFF_FFFC, 32'h2222_2222, 4'hF,    1'b0, 0, 32'h0000_0000, 2'b10};

    bus.req = '0;
    for (int i = 0; i < NR; i++) exp_mem[i] = 32'h0;

    // Reset held for two cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_all_regs("reset");
    chk("reset b_valid",  32'(bus.resp.b_valid),  32'd0);
    chk("reset r_valid",  32'(bus.resp.r_valid),  32'd0);
    chk("reset aw_ready", 32'(bus.resp.aw_ready), 32'd1);
    chk("reset w_ready",  32'(bus.resp.w_ready),  32'd1);
    chk("reset ar_ready", 32'(bus.resp.ar_ready), 32'd1);
    chk("reset pulse",    32'(pulse),             32'd0);
    chk("reset wr_state", 32'(wr_st),             32'(WR_IDLE));
    chk("reset rd_state", 32'(rd_st),             32'(RD_IDLE));

    // Vector table: simultaneous AW+W, then read back the same address
    for (int v = 0; v < 8; v++) begin
      ep = '0;
      if (tbl[v].hit) begin
        exp_mem[tbl[v].idx] = tbl[v].exp_reg;
        ep[tbl[v].idx]      = 1'b1;
      end
      do_write(tbl[v].addr, tbl[v].data, tbl[v].strb, tbl[v].exp_resp, ep,
               $sformatf("vec%0d wr", v));
      do_read(tbl[v].addr, tbl[v].hit ? tbl[v].exp_reg : 32'h0, tbl[v].exp_resp,
              $sformatf("vec%0d rd", v));
    end

    // W three cycles ahead of AW, partial strobe onto reg 2 (all ones)
    bus.req.w.data  = 32'h1122_3344;
    bus.req.w.strb  = 4'b0101;
    bus.req.w_valid = 1'b1;
    bus.req.b_ready = 1'b1;
    chk("wfirst w_ready", 32'(bus.resp.w_ready), 32'd1);
    tick();
    bus.req.w_valid = 1'b0;
    chk("wfirst w_ready_low", 32'(bus.resp.w_ready),  32'd0);
    chk("wfirst aw_ready",    32'(bus.resp.aw_ready), 32'd1);
    chk("wfirst no_b",        32'(bus.resp.b_valid),  32'd0);
    tick();
    tick();
    chk("wfirst reg2_hold", regs[2], 32'hFFFF_FFFF);
    bus.req.aw.addr  = 32'h0000_0008;
    bus.req.aw_valid = 1'b1;
    tick();
    bus.req.aw_valid = 1'b0;
    exp_mem[2] = 32'hFF22_FF44;
    chk("wfirst b_valid", 32'(bus.resp.b_valid), 32'd1);
    chk("wfirst pulse",   32'(pulse),            32'h04);
    chk_all_regs("wfirst");
    tick();
    chk("wfirst b_done",  32'(bus.resp.b_valid), 32'd0);
    chk("wfirst w_ready_back", 32'(bus.resp.w_ready), 32'd1);

    // AW one cycle ahead of W onto reg 5
    bus.req.aw.addr  = 32'h0000_0014;
    bus.req.aw_valid = 1'b1;
    tick();
    bus.req.aw_valid = 1'b0;
    chk("awfirst aw_ready_low", 32'(bus.resp.aw_ready), 32'd0);
    chk("awfirst w_ready",      32'(bus.resp.w_ready),  32'd1);
    chk("awfirst no_b",         32'(bus.resp.b_valid),  32'd0);
    bus.req.w.data  = 32'h0BAD_CAFE;
    bus.req.w.strb  = 4'hF;
    bus.req.w_valid = 1'b1;
    tick();
    bus.req.w_valid = 1'b0;
    exp_mem[5] = 32'h0BAD_CAFE;
    chk("awfirst b_valid", 32'(bus.resp.b_valid), 32'd1);
    chk("awfirst pulse",   32'(pulse),            32'h20);
    chk_all_regs("awfirst");
    tick();

    // Read backpressure: R held for 5 cycles with r_ready low
    bus.req.ar.addr  = 32'h0000_0004;
    bus.req.ar_valid = 1'b1;
    bus.req.r_ready  = 1'b0;
    tick();
    bus.req.ar_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp r_valid c%0d", c),  32'(bus.resp.r_valid),  32'd1);
      chk($sformatf("bp r_data c%0d", c),   bus.resp.r.data,        32'hDEAD_BEEF);
      chk($sformatf("bp ar_ready c%0d", c), 32'(bus.resp.ar_ready), 32'd0);
      tick();
    end
    bus.req.r_ready = 1'b1;
    tick();
    chk("bp r_done",  32'(bus.resp.r_valid),  32'd0);
    chk("bp ar_back", 32'(bus.resp.ar_ready), 32'd1);

    // Read of reg 0 on the edge it is written returns the old value
    bus.req.aw.addr  = 32'h0000_0000;
    bus.req.w.data   = 32'hA5A5_A5A5;
    bus.req.w.strb   = 4'hF;
    bus.req.ar.addr  = 32'h0000_0000;
    bus.req.aw_valid = 1'b1;
    bus.req.w_valid  = 1'b1;
    bus.req.ar_valid = 1'b1;
    bus.req.b_ready  = 1'b1;
    bus.req.r_ready  = 1'b1;
    tick();
    bus.req.aw_valid = 1'b0;
    bus.req.w_valid  = 1'b0;
    bus.req.ar_valid = 1'b0;
    exp_mem[0] = 32'hA5A5_A5A5;
    chk("same r_valid",  32'(bus.resp.r_valid), 32'd1);
    chk("same r_old",    bus.resp.r.data,       32'h0000_0000);
    chk("same b_valid",  32'(bus.resp.b_valid), 32'd1);
    chk("same reg0_new", regs[0],               32'hA5A5_A5A5);
    tick();
    do_read(32'h0000_0000, 32'hA5A5_A5A5, 2'b00, "same rd_after");

    // Reset while B is pending with b_ready low
    bus.req.aw.addr  = 32'h0000_0018;
    bus.req.w.data   = 32'h0000_0077;
    bus.req.w.strb   = 4'hF;
    bus.req.aw_valid = 1'b1;
    bus.req.w_valid  = 1'b1;
    bus.req.b_ready  = 1'b0;
    tick();
    bus.req.aw_valid = 1'b0;
    bus.req.w_valid  = 1'b0;
    chk("midrst b_valid", 32'(bus.resp.b_valid), 32'd1);
    chk("midrst reg6",    regs[6],               32'h0000_0077);
    tick();
    chk("midrst b_held",   32'(bus.resp.b_valid),  32'd1);
    chk("midrst aw_block", 32'(bus.resp.aw_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) exp_mem[i] = 32'h0;
    chk("midrst b_drop",   32'(bus.resp.b_valid),  32'd0);
    chk("midrst aw_ready", 32'(bus.resp.aw_ready), 32'd1);
    chk("midrst w_ready",  32'(bus.resp.w_ready),  32'd1);
    chk_all_regs("midrst");
    exp_mem[6] = 32'h0000_0099;
    do_write(32'h0000_0018, 32'h0000_0099, 4'hF, 2'b00, 8'h40, "postrst wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
